ccc_cfg_sequencer: RTL and testbench
====================================

Name: ccc_cfg_sequencer

Overview:
APB3 slave in the fabric that owns the run-time configuration of the MSS clock-conditioning block's B/C output dividers and bypass selects. On a software "apply" it sequences the change safely: it holds the fabric clock-domain reset, drives the new divider/bypass values, waits for CCC lock to be stable, then releases the reset. The same sequence runs automatically once after power-on reset. The block sits between the MSS APB bus and the CCC configuration inputs and LOCK output.

Parameters:
RST_HOLD, 16, cycles fab_rst_n is held low before new config is driven
LOCK_STABLE, 64, consecutive cycles lock_sync must be high before release
TIMEOUT_DEF, 4096, reset value of TIMEOUT register (cycles to wait for lock)
CNT_W, 16, width of all internal counters and the TIMEOUT register

Ports:
PCLK  in  1  single clock for all logic
PRESERN  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  4  byte address, [1:0] ignored
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied 1 (zero wait)
PSLVERR  out  1  error response
ccc_lock  in  1  CCC LOCK, asynchronous to PCLK
obdiv  out  5  CCC B divider
ocdiv  out  5  CCC C divider
bypass_b  out  1  CCC BYPASSB
bypass_c  out  1  CCC BYPASSC
fab_rst_n  out  1  fabric clock-domain reset, active low
irq  out  1  level interrupt = (done & done_ie) | (err & err_ie) | lock_lost

Behaviour:
- Interface: one clock (PCLK); reset PRESERN is asynchronous, active-low.
- Reset values: obdiv=5'd3, ocdiv=5'd3, bypass_b=1, bypass_c=1, fab_rst_n=0, PRDATA=0, PSLVERR=0, irq=0, all sticky flags 0, TIMEOUT=TIMEOUT_DEF. The FSM resets to ASSERT_RST, giving an automatic power-on sequence.
- ccc_lock passes through a 2-FF synchronizer (lock_sync). Lock-latency counts start from lock_sync.
- Registers:
  - 0x0 CTRL: b0 START (write-1 pulse, reads 0); b1 done_ie; b2 err_ie.
  - 0x4 DIVCFG: [4:0] obdiv_shadow; [12:8] ocdiv_shadow; b16 bypass_b_shadow; b17 bypass_c_shadow.
  - 0x8 STATUS (RO except W1C bits): [2:0] state; b4 busy; b5 lock_sync; b6 err (W1C); b7 done (W1C); b8 lock_lost (W1C).
  - 0xC TIMEOUT: [CNT_W-1:0].
- APB: access phase is PSEL&PENABLE; writes commit on that cycle; PRDATA is combinational from address. PSLVERR=1 on a DIVCFG write while busy; that write is dropped. START while busy is ignored with no error. Unmapped addresses read 0 and ignore writes.
- FSM:
  - IDLE: fab_rst_n=1. START -> ASSERT_RST.
  - ASSERT_RST: fab_rst_n=0; count RST_HOLD cycles -> APPLY.
  - APPLY: 1 cycle; outputs <= shadows -> WAIT_LOCK; the lock counter and timeout counter clear.
  - WAIT_LOCK: lock counter increments while lock_sync=1 and clears to 0 when lock_sync=0. On reaching LOCK_STABLE -> RELEASE. If the timeout counter reaches TIMEOUT first -> ERROR. If both reach their limit in the same cycle, RELEASE wins.
  - RELEASE: fab_rst_n<=1, done<=1 -> IDLE.
  - ERROR: err<=1, fab_rst_n stays 0; START -> ASSERT_RST.
  - busy = state not in {IDLE, ERROR}.
  - Power-on: reset -> ASSERT_RST, which applies the reset-value shadows (equal to the reset outputs).
- lock_lost is set when lock_sync falls while in IDLE. It causes no automatic action.
- TIMEOUT=0 means wait forever.
- Reset asserted mid-sequence returns everything to reset values immediately and restarts the power-on sequence.
- A simultaneous W1C and hardware set of the same flag: the set wins.

Decomposition:
- Package ccc_cfg_pkg holds:
  - state enum (IDLE=0, ASSERT_RST=1, APPLY=2, WAIT_LOCK=3, RELEASE=4, ERROR=5);
  - register offsets;
  - field bit positions;
  - reset constants for obdiv/ocdiv/bypass.
- Sub-module: ccc_lock_sync (2-FF synchronizer with a rising/falling edge pulse output).

Test Plan:
1. Power-on, ccc_lock=1 from cycle 0 -> fab_rst_n rises exactly at cycle 2+RST_HOLD+1+LOCK_STABLE+1 (±1 for synchronizer); STATUS.done=1, obdiv=3.
2. Write DIVCFG=0x0001_0705, START, lock held high -> obdiv=5, ocdiv=7, bypass_b=1, bypass_c=0 from APPLY onward; fab_rst_n low for the whole sequence, then 1; irq=1 if done_ie set; W1C done clears irq.
3. During WAIT_LOCK, toggle ccc_lock low at stable count 40 -> counter restarts; release occurs LOCK_STABLE cycles after the last rising edge of lock_sync.
4. TIMEOUT=100, ccc_lock=0, START -> ERROR after 100 WAIT_LOCK cycles; err=1, fab_rst_n stays 0; raise lock, START -> normal completion.
5. DIVCFG write while busy -> PSLVERR=1, shadow unchanged; START while busy -> no restart.
6. IDLE with lock high, drop ccc_lock -> lock_lost=1, irq=1, fab_rst_n stays 1; assert PRESERN mid-WAIT_LOCK -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ccc_cfg_pkg.sv
// ccc_cfg_pkg: shared types and constants
// for the CCC configuration sequencer.
package ccc_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ASSERT_RST = 3'd1,
    S_APPLY      = 3'd2,
    S_WAIT_LOCK  = 3'd3,
    S_RELEASE    = 3'd4,
    S_ERROR      = 3'd5
  } state_t;

  // word offsets (PADDR[3:2])
  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_DIVCFG  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_TIMEOUT = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DONE_IE = 1;
  localparam int CTRL_ERR_IE  = 2;

  localparam int DIV_OB_LSB = 0;
  localparam int DIV_OC_LSB = 8;
  localparam int DIV_BYP_B  = 16;
  localparam int DIV_BYP_C  = 17;

  localparam int ST_BUSY = 4;
  localparam int ST_LOCK = 5;
  localparam int ST_ERR  = 6;
  localparam int ST_DONE = 7;
  localparam int ST_LOST = 8;

  localparam logic [4:0] OBDIV_RST    = 5'd3;
  localparam logic [4:0] OCDIV_RST    = 5'd3;
  localparam logic       BYPASS_B_RST = 1'b1;
  localparam logic       BYPASS_C_RST = 1'b1;

  typedef struct packed {
    logic       bypass_c;
    logic       bypass_b;
    logic [4:0] ocdiv;
    logic [4:0] obdiv;
  } div_cfg_t;

  localparam div_cfg_t DIV_RST = '{
    bypass_c: BYPASS_C_RST,
    bypass_b: BYPASS_B_RST,
    ocdiv:    OCDIV_RST,
    obdiv:    OBDIV_RST
  };

  function automatic logic is_busy(state_t s);
    return !(s == S_IDLE || s == S_ERROR);
  endfunction

endpackage

// File: rtl/ccc_cfg_sequencer_if.sv
// ccc_cfg_sequencer_if: APB3 bus bundle
// between the MSS master and the sequencer.
interface ccc_cfg_sequencer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ccc_lock_sync.sv
// ccc_lock_sync: 2-FF synchronizer for CCC
// LOCK with rise/fall pulses on the synced value.
module ccc_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // sr[1:0] resolve metastability; sr[2] holds the prior synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], async_in};
  end

  assign sync_out = sr[1];
  assign rise     = sr[1] & ~sr[2];
  assign fall     = ~sr[1] & sr[2];

endmodule

// File: rtl/ccc_cfg_sequencer.sv
// ccc_cfg_sequencer: APB3 owner of CCC B/C
// dividers with a reset/apply/lock sequencer.
module ccc_cfg_sequencer
  import ccc_cfg_pkg::*;
#(
  parameter int RST_HOLD    = 16,
  parameter int LOCK_STABLE = 64,
  parameter int TIMEOUT_DEF = 4096,
  parameter int CNT_W       = 16
) (
  input  logic               PCLK,
  input  logic               PRESERN,
  ccc_cfg_sequencer_if.slave apb,
  input  logic               ccc_lock,
  output logic [4:0]         obdiv,
  output logic [4:0]         ocdiv,
  output logic               bypass_b,
  output logic               bypass_c,
  output logic               fab_rst_n,
  output logic               irq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_RST = CNT_W'(TIMEOUT_DEF);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tmo, tmo_nxt;
  logic [CNT_W-1:0] timeout;
  div_cfg_t         shadow, cfg;
  logic             done_ie, err_ie;
  logic             done, err, lost;
  logic             lock_sync, lock_rise, lock_fall;
  logic             acc, wr, busy, start;
  logic             sel_ctrl, sel_div, sel_stat, sel_tmo;
  logic             wr_ctrl, wr_div, wr_stat, wr_tmo;
  logic             do_apply, set_done, set_err;
  logic             rst_rel, rst_hold;
  logic [1:0]       widx;
  logic             unused_ok;

  ccc_lock_sync u_sync (
    .clk      (PCLK),
    .rst_n    (PRESERN),
    .async_in (ccc_lock),
    .sync_out (lock_sync),
    .rise     (lock_rise),
    .fall     (lock_fall)
  );

  assign widx     = apb.PADDR[3:2];
  assign acc      = apb.PSEL & apb.PENABLE;
  assign wr       = acc & apb.PWRITE;
  assign sel_ctrl = (widx == OFF_CTRL);
  assign sel_div  = (widx == OFF_DIVCFG);
  assign sel_stat = (widx == OFF_STATUS);
  assign sel_tmo  = (widx == OFF_TIMEOUT);
  assign wr_ctrl  = wr & sel_ctrl;
  assign wr_div   = wr & sel_div;
  assign wr_stat  = wr & sel_stat;
  assign wr_tmo   = wr & sel_tmo;
  assign busy     = is_busy(state);
  assign start    = wr_ctrl & apb.PWDATA[CTRL_START];

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = wr_div & busy;

  assign unused_ok = ^{apb.PADDR[1:0], apb.PWDATA, lock_rise};

  // state and sequencing counters
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state <= S_ASSERT_RST;
      cnt   <= '0;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tmo   <= tmo_nxt;
    end
  end

  // next state; lock-stable release beats timeout in the same cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmo_nxt   = tmo;
    do_apply  = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    rst_rel   = 1'b0;
    rst_hold  = 1'b0;
    unique case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_nxt = S_ASSERT_RST;
          cnt_nxt   = '0;
          rst_hold  = 1'b1;
        end
      end
      S_ASSERT_RST: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = S_APPLY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      S_APPLY: begin
        do_apply  = 1'b1;
        cnt_nxt   = '0;
        tmo_nxt   = '0;
        state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        cnt_nxt = lock_sync ? cnt + ONE : '0;
        tmo_nxt = tmo + ONE;
        if (lock_sync && cnt == STABLE_LAST) begin
          state_nxt = S_RELEASE;
        end else if (timeout != '0 && tmo_nxt >= timeout) begin
          state_nxt = S_ERROR;
          set_err   = 1'b1;
        end
      end
      S_RELEASE: begin
        rst_rel   = 1'b1;
        set_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // CCC outputs and fabric reset
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      cfg       <= DIV_RST;
      fab_rst_n <= 1'b0;
    end else begin
      if (do_apply) cfg <= shadow;
      if (rst_rel)       fab_rst_n <= 1'b1;
      else if (rst_hold) fab_rst_n <= 1'b0;
    end
  end

  assign obdiv    = cfg.obdiv;
  assign ocdiv    = cfg.ocdiv;
  assign bypass_b = cfg.bypass_b;
  assign bypass_c = cfg.bypass_c;

  // software registers; DIVCFG writes dropped while busy
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      done_ie <= 1'b0;
      err_ie  <= 1'b0;
      shadow  <= DIV_RST;
      timeout <= TMO_RST;
    end else begin
      if (wr_ctrl) begin
        done_ie <= apb.PWDATA[CTRL_DONE_IE];
        err_ie  <= apb.PWDATA[CTRL_ERR_IE];
      end
      if (wr_div && !busy) begin
        shadow <= '{
          bypass_c: apb.PWDATA[DIV_BYP_C],
          bypass_b: apb.PWDATA[DIV_BYP_B],
          ocdiv:    apb.PWDATA[DIV_OC_LSB +: 5],
          obdiv:    apb.PWDATA[DIV_OB_LSB +: 5]
        };
      end
      if (wr_tmo) timeout <= apb.PWDATA[CNT_W-1:0];
    end
  end

  // sticky flags; hardware set beats a same-cycle W1C
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      done <= 1'b0;
      err  <= 1'b0;
      lost <= 1'b0;
    end else begin
      done <= set_done
            | (done & ~(wr_stat & apb.PWDATA[ST_DONE]));
      err  <= set_err
            | (err & ~(wr_stat & apb.PWDATA[ST_ERR]));
      lost <= (lock_fall & (state == S_IDLE))
            | (lost & ~(wr_stat & apb.PWDATA[ST_LOST]));
    end
  end

  assign irq = (done & done_ie) | (err & err_ie) | lost;

  // read mux, zero when not a read select
  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      unique case (1'b1)
        sel_ctrl: begin
          apb.PRDATA[CTRL_DONE_IE] = done_ie;
          apb.PRDATA[CTRL_ERR_IE]  = err_ie;
        end
        sel_div: begin
          apb.PRDATA[DIV_OB_LSB +: 5] = shadow.obdiv;
          apb.PRDATA[DIV_OC_LSB +: 5] = shadow.ocdiv;
          apb.PRDATA[DIV_BYP_B]       = shadow.bypass_b;
          apb.PRDATA[DIV_BYP_C]       = shadow.bypass_c;
        end
        sel_stat: begin
          apb.PRDATA[2:0]     = state;
          apb.PRDATA[ST_BUSY] = busy;
          apb.PRDATA[ST_LOCK] = lock_sync;
          apb.PRDATA[ST_ERR]  = err;
          apb.PRDATA[ST_DONE] = done;
          apb.PRDATA[ST_LOST] = lost;
        end
        sel_tmo: apb.PRDATA[CNT_W-1:0] = timeout;
        default: apb.PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_cfg_sequencer.sv
// tb_ccc_cfg_sequencer: directed APB scenarios with
// a queued-expectation monitor for bus responses.
module tb_ccc_cfg_sequencer;

  localparam int RST_HOLD    = 16;
  localparam int LOCK_STABLE = 64;
  // cycles from a sequence start edge to fab_rst_n high
  localparam int SEQ_LEN = RST_HOLD + 1 + LOCK_STABLE + 1;

  logic       PCLK = 1'b0;
  logic       PRESERN;
  logic       ccc_lock;
  logic [4:0] obdiv, ocdiv;
  logic       bypass_b, bypass_c, fab_rst_n, irq;

  ccc_cfg_sequencer_if bus ();

  ccc_cfg_sequencer #(
    .RST_HOLD    (RST_HOLD),
    .LOCK_STABLE (LOCK_STABLE),
    .TIMEOUT_DEF (4096),
    .CNT_W       (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESERN   (PRESERN),
    .apb       (bus),
    .ccc_lock  (ccc_lock),
    .obdiv     (obdiv),
    .ocdiv     (ocdiv),
    .bypass_b  (bypass_b),
    .bypass_c  (bypass_c),
    .fab_rst_n (fab_rst_n),
    .irq       (irq)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_exp_t;

  rd_exp_t rdq[$];
  logic    wrq[$];
  string   wrnq[$];
  rd_exp_t mon_rd;
  logic    mon_wr;
  string   mon_nm;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: every access phase pops one expectation
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (bus.PWRITE) begin
        if (wrq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wr_unexpected: write with no expectation");
        end else begin
          mon_wr = wrq.pop_front();
          mon_nm = wrnq.pop_front();
          chk({mon_nm, "_pslverr"}, {31'd0, bus.PSLVERR}, {31'd0, mon_wr});
        end
      end else begin
        if (rdq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected: read with no expectation");
        end else begin
          mon_rd = rdq.pop_front();
          chk(mon_rd.name, bus.PRDATA, mon_rd.exp);
        end
      end
    end
  end

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d,
                        input logic err, input string nm);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = a; bus.PWDATA = d;
    wrq.push_back(err);
    wrnq.push_back(nm);
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a, input logic [31:0] e,
                        input string nm);
    rd_exp_t x;
    x.exp = e;
    x.name = nm;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = a;
    rdq.push_back(x);
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // edges since t0 until the chosen output goes high; -1 if never
  task automatic wait_for(input int t0, input bit use_irq,
                          output int n);
    n = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge PCLK); #1;
      if ((use_irq ? irq : fab_rst_n) === 1'b1) begin
        n = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int t0, n;

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    bus.PADDR = 0; bus.PWDATA = 0;
    ccc_lock = 1'b1;
    PRESERN  = 1'b1;
    #1 PRESERN = 1'b0;
    #3;
    chk("rst_obdiv", 32'(obdiv), 32'd3);
    chk("rst_ocdiv", 32'(ocdiv), 32'd3);
    chk("rst_bypass_b", 32'(bypass_b), 32'd1);
    chk("rst_bypass_c", 32'(bypass_c), 32'd1);
    chk("rst_fab_rst_n", 32'(fab_rst_n), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    chk("rst_prdata", bus.PRDATA, 32'd0);

    // power-on: two reset edges + SEQ_LEN edges = absolute cycle 84
    @(posedge PCLK); @(posedge PCLK); #3;
    PRESERN = 1'b1;
    t0 = cyc;
    wait_for(t0, 1'b0, n);
    chk("por_release_cycle", n, SEQ_LEN);
    chk("por_obdiv", 32'(obdiv), 32'd3);
    apb_rd(4'h8, 32'h0A0, "por_status");

    // new divider config, done interrupt
    apb_wr(4'h8, 32'h80, 1'b0, "w1c_done");
    apb_wr(4'h0, 32'h2, 1'b0, "ctrl_done_ie");
    chk("irq_after_w1c", 32'(irq), 32'd0);
    apb_wr(4'h4, 32'h0001_0705, 1'b0, "divcfg_wr");
    apb_rd(4'h4, 32'h0001_0705, "divcfg_rd");
    apb_wr(4'h0, 32'h3, 1'b0, "start_cfg");
    t0 = cyc;
    repeat (10) @(posedge PCLK);
    #1;
    chk("hold_obdiv_old", 32'(obdiv), 32'd3);
    chk("hold_fab_rst_n", 32'(fab_rst_n), 32'd0);
    repeat (8) @(posedge PCLK);
    #1;
    chk("apply_obdiv", 32'(obdiv), 32'd5);
    chk("apply_ocdiv", 32'(ocdiv), 32'd7);
    chk("apply_bypass_b", 32'(bypass_b), 32'd1);
    chk("apply_bypass_c", 32'(bypass_c), 32'd0);
    chk("apply_fab_rst_n", 32'(fab_rst_n), 32'd0);
    wait_for(t0, 1'b0, n);
    chk("cfg_release_cycle", n, SEQ_LEN);
    chk("done_irq", 32'(irq), 32'd1);
    apb_wr(4'h8, 32'h80, 1'b0, "w1c_done2");
    chk("done_irq_cleared", 32'(irq), 32'd0);
    apb_rd(4'h8, 32'h020, "status_idle");

    // lock glitch at stable count 40: lock_sync low edges 60..64,
    // high again after edge 64, release LOCK_STABLE edges later
    apb_wr(4'h0, 32'h3, 1'b0, "start_glitch");
    t0 = cyc;
    repeat (57) @(posedge PCLK);
    #1 ccc_lock = 1'b0;
    repeat (5) @(posedge PCLK);
    #1 ccc_lock = 1'b1;
    wait_for(t0, 1'b0, n);
    chk("glitch_release_cycle", n, 62 + 2 + LOCK_STABLE + 1);
    chk("glitch_done_irq", 32'(irq), 32'd1);

    // lock loss while idle
    apb_wr(4'h0, 32'h0, 1'b0, "ctrl_clear");
    apb_wr(4'h8, 32'h1C0, 1'b0, "w1c_all");
    chk("idle_irq_clear", 32'(irq), 32'd0);
    ccc_lock = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    chk("lost_irq", 32'(irq), 32'd1);
    chk("lost_fab_rst_n", 32'(fab_rst_n), 32'd1);
    apb_rd(4'h8, 32'h100, "status_lost");
    apb_wr(4'h8, 32'h100, 1'b0, "w1c_lost");
    chk("lost_irq_cleared", 32'(irq), 32'd0);

    // timeout: 100 WAIT_LOCK cycles then ERROR
    apb_wr(4'hC, 32'd100, 1'b0, "timeout_wr");
    apb_rd(4'hC, 32'd100, "timeout_rd");
    apb_wr(4'h0, 32'h5, 1'b0, "start_timeout");
    t0 = cyc;
    wait_for(t0, 1'b1, n);
    chk("err_cycle", n, RST_HOLD + 1 + 100);
    chk("err_fab_rst_n", 32'(fab_rst_n), 32'd0);
    repeat (20) @(posedge PCLK);
    #1;
    chk("err_fab_rst_n_hold", 32'(fab_rst_n), 32'd0);
    apb_rd(4'h8, 32'h045, "status_error");
    ccc_lock = 1'b1;
    repeat (3) @(posedge PCLK);
    apb_wr(4'h8, 32'h40, 1'b0, "w1c_err");
    chk("err_irq_cleared", 32'(irq), 32'd0);
    apb_wr(4'h0, 32'h1, 1'b0, "start_recover");
    t0 = cyc;
    wait_for(t0, 1'b0, n);
    chk("recover_release_cycle", n, SEQ_LEN);

    // busy: DIVCFG rejected, START ignored
    apb_wr(4'h0, 32'h1, 1'b0, "start_busy_seq");
    t0 = cyc;
    apb_wr(4'h4, 32'h1F, 1'b1, "divcfg_busy");
    apb_wr(4'h0, 32'h1, 1'b0, "start_while_busy");
    apb_rd(4'h4, 32'h0001_0705, "divcfg_kept");
    wait_for(t0, 1'b0, n);
    chk("busy_release_cycle", n, SEQ_LEN);

    // reset mid WAIT_LOCK
    apb_wr(4'h0, 32'h3, 1'b0, "start_reset_seq");
    repeat (30) @(posedge PCLK);
    #1;
    chk("pre_reset_obdiv", 32'(obdiv), 32'd5);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    PRESERN = 1'b0;
    #1;
    chk("mid_rst_obdiv", 32'(obdiv), 32'd3);
    chk("mid_rst_ocdiv", 32'(ocdiv), 32'd3);
    chk("mid_rst_bypass_b", 32'(bypass_b), 32'd1);
    chk("mid_rst_bypass_c", 32'(bypass_c), 32'd1);
    chk("mid_rst_fab_rst_n", 32'(fab_rst_n), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    @(posedge PCLK); @(posedge PCLK); #3;
    PRESERN = 1'b1;
    t0 = cyc;
    wait_for(t0, 1'b0, n);
    chk("restart_release_cycle", n, SEQ_LEN);
    apb_rd(4'h4, 32'h0003_0303, "divcfg_rst");
    apb_rd(4'hC, 32'h0000_1000, "timeout_rst");
    apb_rd(4'h0, 32'h0, "ctrl_rst");

    repeat (2) @(posedge PCLK);
    chk("rd_queue_drained", rdq.size(), 0);
    chk("wr_queue_drained", wrq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
